// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-RAM port among NUM_PORTS masters, one transaction in flight.
// Optional DMEM_ARB_RANGE_CHECK_EN: out-of-range accesses skip the RAM and complete with m_err.
module dmem_arbiter #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DMEM_SIZE  = 512,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PORTS-1:0]      m_req,
    input  logic [NUM_PORTS-1:0]      m_we,
    input  logic [32*NUM_PORTS-1:0]   m_addr,
    input  logic [32*NUM_PORTS-1:0]   m_wdata,
    input  logic [4*NUM_PORTS-1:0]    m_be,
    output logic [NUM_PORTS-1:0]      m_gnt,
    output logic [NUM_PORTS-1:0]      m_rvalid,
    output logic [NUM_PORTS-1:0]      m_err,
    output logic [31:0]               m_rdata,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    output logic [3:0]                mem_be,
    input  logic [31:0]               mem_rdata
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNT_W = 2;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

    if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_ports
        $error("dmem_arbiter: NUM_PORTS must be 2..8");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("dmem_arbiter: RD_LATENCY must be 1..4");
    end
    if (DMEM_SIZE == 0) begin : g_bad_size
        $error("dmem_arbiter: DMEM_SIZE must be non-zero");
    end

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       pend_idx_q, pend_idx_d;
    logic                   pend_err_q, pend_err_d;
    logic [NUM_PORTS-1:0]   m_rvalid_q, m_rvalid_d;
    logic [NUM_PORTS-1:0]   m_err_q, m_err_d;

    logic                   arb_en;
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic                   grant;
    logic                   addr_err;
    logic                   mem_access;
    logic                   sel_we;
    logic [31:0]            sel_addr;
    logic [31:0]            sel_wdata;
    logic [3:0]             sel_be;
    logic                   done_next;
    logic [IDX_W-1:0]       done_idx;
    logic                   done_err;

    // Rotating priority: first requester at or above rr_ptr, else lowest requester below it.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int j = 0; j < int'(NUM_PORTS); j++) begin
            if (!win_found && m_req[j] && (IDX_W'(j) >= rr_ptr_q)) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
        for (int j = 0; j < int'(NUM_PORTS); j++) begin
            if (!win_found && m_req[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
        arb_en = !rst && ((state_q == ST_IDLE) || (cnt_q == '0));
        grant  = arb_en && win_found;
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        m_gnt     = '0;
        for (int j = 0; j < int'(NUM_PORTS); j++) begin
            if (IDX_W'(j) == win_idx) begin
                sel_we    = m_we[j];
                sel_addr  = m_addr[32*j +: 32];
                sel_wdata = m_wdata[32*j +: 32];
                sel_be    = m_be[4*j +: 4];
                m_gnt[j]  = grant;
            end
        end
    end

`ifdef DMEM_ARB_RANGE_CHECK_EN
    assign addr_err = (sel_addr >= 32'(DMEM_SIZE));
`else
    assign addr_err = 1'b0;
`endif

    assign mem_access = grant && !addr_err;
    assign mem_req    = mem_access;
    assign mem_we     = mem_access && sel_we;
    assign mem_addr   = mem_access ? sel_addr  : '0;
    assign mem_wdata  = mem_access ? sel_wdata : '0;
    assign mem_be     = mem_access ? sel_be    : '0;

    // Next state; the completion strobe is set one cycle ahead so it leaves a flop at T+RD_LATENCY.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;
        pend_idx_d = pend_idx_q;
        pend_err_d = pend_err_q;
        done_next  = 1'b0;
        done_idx   = pend_idx_q;
        done_err   = pend_err_q;
        m_rvalid_d = '0;
        m_err_d    = '0;

        if (grant) begin
            state_d    = ST_BUSY;
            cnt_d      = CNT_W'(RD_LATENCY - 1);
            rr_ptr_d   = (32'(win_idx) == NUM_PORTS - 1) ? '0 : win_idx + IDX_W'(1);
            pend_idx_d = win_idx;
            pend_err_d = addr_err;
            done_next  = (RD_LATENCY == 1);
            done_idx   = win_idx;
            done_err   = addr_err;
        end else if (state_q == ST_BUSY) begin
            if (cnt_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d     = cnt_q - CNT_W'(1);
                done_next = (cnt_q == CNT_W'(1));
            end
        end

        for (int j = 0; j < int'(NUM_PORTS); j++) begin
            if (done_next && (IDX_W'(j) == done_idx)) begin
                m_rvalid_d[j] = 1'b1;
                m_err_d[j]    = done_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rr_ptr_q   <= '0;
            pend_idx_q <= '0;
            pend_err_q <= 1'b0;
            m_rvalid_q <= '0;
            m_err_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            pend_idx_q <= pend_idx_d;
            pend_err_q <= pend_err_d;
            m_rvalid_q <= m_rvalid_d;
            m_err_q    <= m_err_d;
        end
    end

    assign m_rvalid = m_rvalid_q;
    assign m_err    = m_err_q;
    assign m_rdata  = ((|m_rvalid_q) && !(|m_err_q)) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Random-traffic bench for dmem_arbiter: two instances (RD_LATENCY 1 and 3, three masters each)
// against a transaction-level model of grants, completions and memory contents.
module tb_dmem_arbiter;

    localparam int NP = 3;
    localparam int NI = 2;
    localparam int NCYC = 1600;

    logic clk = 1'b0;
    logic rst;
    logic env_init = 1'b1;

    logic [NP-1:0]    m_req     [NI];
    logic [NP-1:0]    m_we      [NI];
    logic [32*NP-1:0] m_addr    [NI];
    logic [32*NP-1:0] m_wdata   [NI];
    logic [4*NP-1:0]  m_be      [NI];
    logic [NP-1:0]    m_gnt     [NI];
    logic [NP-1:0]    m_rvalid  [NI];
    logic [NP-1:0]    m_err     [NI];
    logic [31:0]      m_rdata   [NI];
    logic             mem_req   [NI];
    logic             mem_we    [NI];
    logic [31:0]      mem_addr  [NI];
    logic [31:0]      mem_wdata [NI];
    logic [3:0]       mem_be    [NI];
    logic [31:0]      mem_rdata [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_arbiter #(
            .NUM_PORTS  (NP),
            .DMEM_SIZE  (512),
            .RD_LATENCY ((g == 0) ? 1 : 3)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .m_req     (m_req[g]),
            .m_we      (m_we[g]),
            .m_addr    (m_addr[g]),
            .m_wdata   (m_wdata[g]),
            .m_be      (m_be[g]),
            .m_gnt     (m_gnt[g]),
            .m_rvalid  (m_rvalid[g]),
            .m_err     (m_err[g]),
            .m_rdata   (m_rdata[g]),
            .mem_req   (mem_req[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_be    (mem_be[g]),
            .mem_rdata (mem_rdata[g])
        );
    end

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] seed_word(input int k, input int i);
        return (32'(i + 1) * 32'h9E37_79B1) ^ 32'(k << 20);
    endfunction

    // RAM behind each arbiter: byte-enabled writes, reads appear lat(k) cycles later, garbage otherwise.
    logic [31:0] ram  [NI][256];
    logic [31:0] pipe [NI][4];

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            for (int s = 3; s > 0; s--) pipe[k][s] <= pipe[k][s-1];
            pipe[k][0] <= $urandom;
            if (env_init) begin
                for (int i = 0; i < 256; i++) ram[k][i] <= seed_word(k, i);
            end else if (mem_req[k]) begin
                if (mem_we[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[k][b]) ram[k][mem_addr[k][9:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
                end else begin
                    pipe[k][0] <= ram[k][mem_addr[k][9:2]];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NI; k++) mem_rdata[k] = pipe[k][lat(k) - 1];
    end

    // Reference model state: master behaviour, round-robin pointer, outstanding responses, memory image.
    int          cyc;
    int          n_checks;
    int          n_errors;
    int          rr       [NI];
    int          next_arb [NI];
    int          mst      [NI][NP];   // 0 idle, 1 requesting, 2 awaiting response
    bit          pl_we    [NI][NP];
    logic [31:0] pl_addr  [NI][NP];
    logic [31:0] pl_wdata [NI][NP];
    logic [3:0]  pl_be    [NI][NP];
    bit          pend     [NI][NP];
    int          due      [NI][NP];
    bit          pend_rd  [NI][NP];
    bit          pend_err [NI][NP];
    logic [31:0] pend_dat [NI][NP];
    logic [31:0] mdl      [NI][256];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic new_request(input int k, input int p);
        int r;
        r = $urandom_range(15);
        mst[k][p]      = 1;
        pl_we[k][p]    = 1'($urandom_range(1));
        pl_wdata[k][p] = $urandom;
        pl_be[k][p]    = 4'($urandom);
        if (r == 0)      pl_addr[k][p] = $urandom & 32'hFFFF_FFFC;
        else if (r == 1) pl_addr[k][p] = 32'h0000_0200;
        else if (r == 2) pl_addr[k][p] = 32'h0000_01FC;
        else             pl_addr[k][p] = {22'h0, 8'($urandom_range(255)), 2'b00};
    endtask

    task automatic drive_inputs(input int prob);
        for (int k = 0; k < NI; k++) begin
            for (int p = 0; p < NP; p++) begin
                if (mst[k][p] == 0 && $urandom_range(99) < prob) new_request(k, p);
                if (mst[k][p] == 1) begin
                    m_req[k][p]            = 1'b1;
                    m_we[k][p]             = pl_we[k][p];
                    m_addr[k][32*p +: 32]  = pl_addr[k][p];
                    m_wdata[k][32*p +: 32] = pl_wdata[k][p];
                    m_be[k][4*p +: 4]      = pl_be[k][p];
                end else begin
                    m_req[k][p]            = 1'b0;
                    m_we[k][p]             = 1'($urandom_range(1));
                    m_addr[k][32*p +: 32]  = $urandom;
                    m_wdata[k][32*p +: 32] = $urandom;
                    m_be[k][4*p +: 4]      = 4'($urandom);
                end
            end
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            logic [NP-1:0] e_gnt, e_rv, e_err;
            logic          e_mreq, e_mwe;
            logic [31:0]   e_maddr, e_mwdata, e_rdata;
            logic [3:0]    e_mbe;
            bit            oob, chk_rdata;
            int            win, w_idx;
            string         pre;

            e_gnt = '0; e_rv = '0; e_err = '0;
            e_mreq = 1'b0; e_mwe = 1'b0; e_maddr = '0; e_mwdata = '0; e_mbe = '0;
            e_rdata = '0; chk_rdata = 1'b1; oob = 1'b0; win = -1;

            if (!rst) begin
                for (int p = 0; p < NP; p++) begin
                    if (pend[k][p] && due[k][p] == cyc) begin
                        e_rv[p]  = 1'b1;
                        e_err[p] = pend_err[k][p];
                        if (pend_err[k][p])     e_rdata = '0;
                        else if (pend_rd[k][p]) e_rdata = pend_dat[k][p];
                        else                    chk_rdata = 1'b0;
                    end
                end
                if (cyc >= next_arb[k]) begin
                    for (int i = 0; i < NP; i++) begin
                        int pp;
                        pp = (rr[k] + i) % NP;
                        if (win < 0 && mst[k][pp] == 1) win = pp;
                    end
                end
                if (win >= 0) begin
`ifdef DMEM_ARB_RANGE_CHECK_EN
                    oob = (pl_addr[k][win] >= 32'd512);
`endif
                    e_gnt[win] = 1'b1;
                    if (!oob) begin
                        e_mreq   = 1'b1;
                        e_mwe    = pl_we[k][win];
                        e_maddr  = pl_addr[k][win];
                        e_mwdata = pl_wdata[k][win];
                        e_mbe    = pl_be[k][win];
                    end
                end
            end

            pre = $sformatf("i%0d c%0d", k, cyc);
            check_eq({pre, " m_gnt"},     32'(m_gnt[k]),    32'(e_gnt));
            check_eq({pre, " mem_req"},   32'(mem_req[k]),  32'(e_mreq));
            check_eq({pre, " mem_we"},    32'(mem_we[k]),   32'(e_mwe));
            check_eq({pre, " mem_addr"},  mem_addr[k],      e_maddr);
            check_eq({pre, " mem_wdata"}, mem_wdata[k],     e_mwdata);
            check_eq({pre, " mem_be"},    32'(mem_be[k]),   32'(e_mbe));
            check_eq({pre, " m_rvalid"},  32'(m_rvalid[k]), 32'(e_rv));
            check_eq({pre, " m_err"},     32'(m_err[k]),    32'(e_err));
            if (chk_rdata) check_eq({pre, " m_rdata"}, m_rdata[k], e_rdata);

            if (rst) begin
                for (int p = 0; p < NP; p++) begin
                    pend[k][p] = 1'b0;
                    if (mst[k][p] == 2) mst[k][p] = 0;
                end
                rr[k]       = 0;
                next_arb[k] = 0;
            end else begin
                for (int p = 0; p < NP; p++) begin
                    if (e_rv[p]) begin
                        pend[k][p] = 1'b0;
                        mst[k][p]  = 0;
                    end
                end
                if (win >= 0) begin
                    w_idx           = int'(pl_addr[k][win][9:2]);
                    mst[k][win]      = 2;
                    pend[k][win]     = 1'b1;
                    due[k][win]      = cyc + lat(k);
                    pend_err[k][win] = oob;
                    pend_rd[k][win]  = !pl_we[k][win];
                    pend_dat[k][win] = mdl[k][w_idx];
                    if (pl_we[k][win] && !oob) begin
                        for (int b = 0; b < 4; b++)
                            if (pl_be[k][win][b]) mdl[k][w_idx][8*b +: 8] = pl_wdata[k][win][8*b +: 8];
                    end
                    rr[k]       = (win + 1) % NP;
                    next_arb[k] = cyc + lat(k);
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        cyc      = 0;
        n_checks = 0;
        n_errors = 0;
        for (int k = 0; k < NI; k++) begin
            rr[k]       = 0;
            next_arb[k] = 0;
            for (int p = 0; p < NP; p++) begin
                mst[k][p]  = 0;
                pend[k][p] = 1'b0;
                due[k][p]  = 0;
            end
            for (int i = 0; i < 256; i++) mdl[k][i] = seed_word(k, i);
        end
        drive_inputs(0);

        for (int c = 0; c < NCYC; c++) begin
            int prob;
            @(posedge clk);
            cyc++;
            #1;
            if (c == 2) env_init = 1'b0;
            if (c == 4) rst = 1'b0;
            // Mid-traffic reset with every master requesting, so the first grant afterwards shows rr_ptr=0.
            if (c % 400 == 200) begin
                rst = 1'b1;
                for (int k = 0; k < NI; k++)
                    for (int p = 0; p < NP; p++)
                        if (mst[k][p] != 1) new_request(k, p);
            end
            if (c % 400 == 203) rst = 1'b0;
            case ((c / 150) % 3)
                0:       prob = 35;
                1:       prob = 100;
                default: prob = 70;
            endcase
            drive_inputs(prob);
            @(negedge clk);
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Parametrised data-memory front end that lets `NUM_PORTS` masters (core data port plus further agents such as a DMA or debug unit) share the single data port of the unified RAM. It arbitrates round-robin, allows one outstanding transaction at a time, and tracks a configurable memory read latency. It returns a per-port completion strobe (`m_rvalid`) with read data. It sits between the masters and the RAM data port.

## Interface
- `NUM_PORTS`, 2: number of masters, 2..8.
- `DMEM_SIZE`, 512: data memory size in bytes; used by the range check.
- `RD_LATENCY`, 1: cycles from `mem_req` to valid `mem_rdata`, 1..4.

Ports (port i of a flattened bus occupies slice `[W*i +: W]`):
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `m_req`  in  NUM_PORTS  request per master.
- `m_we`  in  NUM_PORTS  1 = write.
- `m_addr`  in  32*NUM_PORTS  byte address.
- `m_wdata`  in  32*NUM_PORTS  write data.
- `m_be`  in  4*NUM_PORTS  byte enables.
- `m_gnt`  out  NUM_PORTS  grant, one-hot or zero, combinational.
- `m_rvalid`  out  NUM_PORTS  completion strobe, one cycle, registered.
- `m_err`  out  NUM_PORTS  error qualifier, valid with `m_rvalid`.
- `m_rdata`  out  32  read data, shared, valid with `m_rvalid`.
- `mem_req`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  32  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_be`  out  4  memory byte enables.
- `mem_rdata`  in  32  memory read data, valid `RD_LATENCY` cycles after `mem_req`.

## Operation
- States:
  - IDLE: no transaction in flight.
  - BUSY: waiting on a response. A latency counter `cnt` is loaded with `RD_LATENCY-1` on grant.
- Arbitration happens in IDLE, or in the final BUSY cycle (`cnt==0`):
  - The search over `m_req` starts at `rr_ptr` and wraps modulo `NUM_PORTS`. The first set bit is the winner `w`.
  - `m_gnt[w]=1`, `mem_*` are driven from port w, and `rr_ptr <= (w+1) mod NUM_PORTS`.
- Master rules:
  - A master holds `m_req` and its payload stable until it sees `m_gnt`.
  - It may drop or change them in the cycle after the grant.
  - A master must not expect a grant while it is waiting for its own `m_rvalid`.
- When there is no grant: `mem_req=0`, `mem_we=0`, `mem_be=0`, `mem_addr=0`, `mem_wdata=0`.
- Completion for a grant at cycle T:
  - `m_rvalid[w]=1` for exactly one cycle at T+RD_LATENCY.
  - `m_rdata=mem_rdata` in that cycle. For writes `m_rdata` is don't-care.
  - Writes also return `m_rvalid`.
- `m_rdata=0` whenever no `m_rvalid` bit is set.
- When the BUSY state expires with no new request, the block returns to IDLE. With a new request it re-grants and stays in BUSY.
- Reset values:
  - `rr_ptr=0`, state IDLE, `cnt=0`.
  - `m_rvalid=0`, `m_err=0`.
  - While `rst` is high, `m_gnt` and `mem_req` are forced to 0.
- Reset mid-transaction: the pending response is discarded, and no `m_rvalid` appears after `rst` falls.

## Timing
- Grant latency: 0 cycles, with `m_gnt` and `mem_req` in the same cycle as `m_req` when the block is idle.
- Completion latency: exactly `RD_LATENCY` cycles after grant.
- Peak throughput: one transaction per `RD_LATENCY` cycles. A back-to-back grant is allowed in the completion cycle.
- Fairness: under continuous requests from all ports, each port is granted once every `NUM_PORTS` grants.
- Combinational paths:
  - `m_req` → `m_gnt` and `m_req` → `mem_*`.
  - `mem_rdata` → `m_rdata`.
  - No path from `mem_rdata` to `m_gnt`.

## Configuration
- Macro: `DMEM_ARB_RANGE_CHECK_EN`.
- Defined:
  - A granted access with `addr >= DMEM_SIZE` keeps `mem_req=0`; no memory access occurs.
  - At T+RD_LATENCY it returns `m_rvalid[w]=1`, `m_err[w]=1`, `m_rdata=0`.
  - Arbitration and pointer update are unchanged.
- Undefined:
  - `m_err` is tied to 0.
  - Every granted access drives `mem_req=1` with the address passed through unchanged.

## Test plan
- Single read, `RD_LATENCY=1`, port 0 reads `0x10` holding `0xDEADBEEF`:
  - Cycle T: `m_gnt=2'b01`, `mem_req=1`, `mem_addr=0x10`.
  - T+1: `m_rvalid=2'b01`, `m_rdata=0xDEADBEEF`.
- Contention, `NUM_PORTS=2`, both ports hold requests from reset:
  - Grants alternate port0, port1, port0, port1 at T, T+1, T+2, T+3.
  - Each `m_rvalid` lands on the matching port one cycle after its grant.
- Write then read, port 1:
  - Write `0x12345678` with `be=4'b0011` to `0x20`: `mem_we=1`, `mem_be=4'b0011`, and `m_rvalid[1]` at T+1.
  - A read of `0x20` over the old value `0x00000000` returns `0x00005678`.
- `RD_LATENCY=3`, port 0 requesting continuously:
  - Grants at T, T+3, T+6.
  - `m_rvalid[0]` at T+3, T+6, T+9.
  - `mem_req` is low at T+1, T+2, T+4, T+5.
- Range check, `DMEM_SIZE=512`, read at `0x200`:
  - With macro: `mem_req` stays 0; at T+1 `m_rvalid[0]=1`, `m_err[0]=1`, `m_rdata=0`.
  - Without macro: `mem_req=1` at T, and `m_err` stays 0.
- Reset mid-operation, `RD_LATENCY=3`:
  - Assert `rst` at T+1 after a port 1 grant at T.
  - No `m_rvalid` is seen through T+6.
  - `m_gnt=0` while `rst` is high.
  - After release, simultaneous requests grant port 0 first (`rr_ptr=0`).
